haraka_s_sponge_ctrl: RTL and testbench
=======================================

Name: haraka_s_sponge_ctrl

Overview:
Control FSM for the Haraka-S sponge datapath. It accepts padded 32-byte rate blocks through a valid/ready handshake and sequences absorb, the permutation rounds and squeeze. It drives the round index that selects the round-constant group, and emits digest blocks with a per-block byte count. It holds no rate/capacity data itself; it only issues strobes to the datapath and serializer.

Parameters:
NUM_ROUNDS, 5, permutation rounds per call (8 round constants per round)
RND_W, 3, width of perm_round, ≥ $clog2(NUM_ROUNDS)
RATE_BYTES, 32, bytes per rate block
LEN_W, 64, width of digest_len

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
in_valid  in  1  padded block available on the datapath input
in_last  in  1  qualifies in_valid: final padded block of the message
in_ready  out  1  controller accepts a block this cycle
digest_len  in  LEN_W  requested digest length in bytes; sampled on the first block
state_clr  out  1  datapath zeroes rate/capacity before XOR (first block only)
absorb_en  out  1  datapath XORs the input block into rate at this edge
perm_round_en  out  1  datapath applies one round this edge
perm_round  out  RND_W  round index; selects round constants round*8..round*8+7
out_valid  out  1  rate holds digest bytes
out_ready  in  1  serializer takes the block
out_nbytes  out  6  valid bytes in the block, 1..32
out_last  out  1  final digest block
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a message completes

Behaviour:
- Reset:
  - State goes to IDLE at the next edge.
  - in_ready=1 in IDLE; all other outputs are 0.
  - The remaining-byte counter and last flag clear.
  - Reset mid-operation aborts the message with no done pulse.
- States: IDLE, ABSORB, PERM, SQ_OUT, SQ_PERM.
- in_ready=1 only in IDLE and ABSORB. A handshake is in_valid&in_ready.
- absorb_en = handshake (combinational). state_clr = handshake in IDLE.
- IDLE handshake:
  - Latch rem=digest_len and last=in_last.
  - Go to PERM with round counter 0.
- ABSORB handshake: latch last=in_last, then go to PERM.
- PERM:
  - perm_round_en=1 and perm_round=counter for NUM_ROUNDS consecutive cycles; the counter increments each cycle.
  - On the last round (counter=NUM_ROUNDS-1), choose the next state:
    - last=0: go to ABSORB.
    - last=1 and rem≠0: go to SQ_OUT.
    - last=1 and rem=0: go to IDLE and pulse done.
  - Latency: block accepted at cycle t, rounds at t+1..t+5, in_ready or out_valid high at t+6.
- perm_round=0 whenever perm_round_en=0.
- SQ_OUT:
  - out_valid=1, out_nbytes=min(rem,32), out_last=(rem≤32). These hold stable until the handshake.
  - On out_valid&out_ready: rem -= out_nbytes.
  - If out_last: go to IDLE and pulse done in the same cycle as the handshake.
  - Otherwise go to SQ_PERM.
- SQ_PERM: NUM_ROUNDS rounds exactly as in PERM, with absorb_en=0, then back to SQ_OUT.
- The min/compare uses the full LEN_W width. rem=2^64-1 must not overflow, and its final block has 31 bytes.
- in_valid while in_ready=0 is ignored; the source holds the block.
- Changes to digest_len after the first handshake are ignored.
- out_ready asserted when out_valid=0 has no effect.
- busy=0 only in IDLE.

Decomposition:
- Package haraka_pkg holds:
  - NUM_ROUNDS and RATE_BYTES constants
  - enum typedef haraka_ctrl_state_t {IDLE, ABSORB, PERM, SQ_OUT, SQ_PERM}
  - the 40×128 round-constant table, shared with the datapath
- Sub-module haraka_s_round_seq: round counter with start/last_round outputs, reused by PERM and SQ_PERM.

Test Plan:
- Single block, in_last=1, digest_len=32 → absorb_en and state_clr high at t. perm_round 0,1,2,3,4 at t+1..t+5. out_valid at t+6 with nbytes=32, out_last=1. done on the handshake.
- Three blocks, last on the third, digest_len=64 → 15 round cycles. in_ready=0 during every PERM. state_clr only on block 1. Two output blocks of 32,32 separated by 5 SQ_PERM rounds.
- digest_len=45 with out_ready held 0 for 10 cycles → out_valid and nbytes=32 stable throughout. After the handshake, a second block with nbytes=13 and out_last=1.
- digest_len=0 → no out_valid. done pulses at t+5 and the FSM returns to IDLE.
- Reset asserted during SQ_PERM round 2 → next cycle in IDLE, busy=0, perm_round_en=0, no done. A new message then runs normally.
- digest_len=2^64-1 for 2 blocks → nbytes=32 each. rem decrements correctly and out_last stays 0.

Source files
------------

// File: rtl/haraka_pkg.sv
// -----------------------------------------------------------------------------
// haraka_pkg
//   Shared definitions for the Haraka-S sponge controller and its datapath.
//   - NUM_ROUNDS / RATE_BYTES : permutation rounds per call, rate block size
//   - RC_PER_ROUND / NUM_RC   : round-constant grouping (8 constants per round)
//   - haraka_ctrl_state_t     : controller FSM encoding
//   - haraka_rc_table_t       : shape of the 40 x 128-bit round-constant table
//   - rc_index()              : first constant index used by a given round
// -----------------------------------------------------------------------------
package haraka_pkg;

  localparam int NUM_ROUNDS   = 5;
  localparam int RATE_BYTES   = 32;
  localparam int RC_PER_ROUND = 8;
  localparam int NUM_RC       = NUM_ROUNDS * RC_PER_ROUND;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ABSORB  = 3'd1,
    PERM    = 3'd2,
    SQ_OUT  = 3'd3,
    SQ_PERM = 3'd4
  } haraka_ctrl_state_t;

  // One 128-bit constant per AES lane; the datapath holds the table contents
  // in this shape and indexes it with rc_index() + lane.
  typedef logic [127:0] haraka_rc_word_t;
  typedef haraka_rc_word_t haraka_rc_table_t [NUM_RC];

  // perm_round selects constants round*8 .. round*8+7.
  function automatic int unsigned rc_index(input logic [2:0] round);
    return 32'(round) * 32'(RC_PER_ROUND);
  endfunction

endpackage

// File: rtl/haraka_s_round_seq.sv
// -----------------------------------------------------------------------------
// haraka_s_round_seq
//   Round counter shared by the PERM and SQ_PERM phases. A start pulse arms a
//   run of NUM_ROUNDS consecutive cycles; round_en is high and round counts
//   0..NUM_ROUNDS-1 during the run. round returns to 0 when idle.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   start      : begin a new run at the next edge (round 0 in the next cycle)
//   round_en   : a round is being applied this cycle (registered)
//   round      : current round index (registered, 0 when round_en=0)
//   last_round : this cycle is the final round of the run
// -----------------------------------------------------------------------------
module haraka_s_round_seq
  import haraka_pkg::*;
#(
  parameter int NUM_ROUNDS = haraka_pkg::NUM_ROUNDS,
  parameter int RND_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             round_en,
  output logic [RND_W-1:0] round,
  output logic             last_round
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  logic             active_r;
  logic [RND_W-1:0] round_r;

  // Run/round counter: start wins over an in-progress run.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r <= 1'b0;
      round_r  <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      round_r  <= '0;
    end else if (active_r) begin
      if (round_r == LAST_RND) begin
        active_r <= 1'b0;
        round_r  <= '0;
      end else begin
        round_r  <= round_r + {{(RND_W-1){1'b0}}, 1'b1};
      end
    end else begin
      active_r <= 1'b0;
      round_r  <= '0;
    end
  end

  assign round_en   = active_r;
  assign round      = round_r;
  assign last_round = active_r & (round_r == LAST_RND);

endmodule

// File: rtl/haraka_s_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// haraka_s_sponge_ctrl
//   Control FSM for the Haraka-S sponge. Accepts padded rate blocks, runs
//   NUM_ROUNDS permutation rounds after each absorb, then squeezes digest
//   blocks (one permutation between consecutive output blocks) until the
//   requested digest length has been emitted. Holds no rate/capacity data.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   in_valid/in_last       : padded block available / it is the final block
//   in_ready               : block accepted when in_valid & in_ready
//   digest_len             : digest length in bytes, sampled on the first block
//   state_clr, absorb_en   : datapath strobes (clear state / XOR block in)
//   perm_round_en/round    : datapath round strobe and constant-group index
//   out_valid/out_ready    : digest block handshake to the serializer
//   out_nbytes, out_last   : valid bytes in the block (1..32), final block
//   busy, done             : not idle / one-cycle completion pulse
// -----------------------------------------------------------------------------
module haraka_s_sponge_ctrl
  import haraka_pkg::*;
#(
  parameter int NUM_ROUNDS = haraka_pkg::NUM_ROUNDS,
  parameter int RND_W      = 3,
  parameter int RATE_BYTES = haraka_pkg::RATE_BYTES,
  parameter int LEN_W      = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [LEN_W-1:0] digest_len,
  output logic             state_clr,
  output logic             absorb_en,
  output logic             perm_round_en,
  output logic [RND_W-1:0] perm_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_nbytes,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // Bytes carried by the next output block: min(rem, RATE_BYTES), compared
  // at full width so huge remaining counts never alias into the low bits.
  function automatic logic [5:0] block_bytes(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(RATE_BYTES)) begin
      return 6'(RATE_BYTES);
    end else begin
      return rem[5:0];
    end
  endfunction

  // The block is the final one when at most one rate block remains.
  function automatic logic is_final(input logic [LEN_W-1:0] rem);
    return (rem <= LEN_W'(RATE_BYTES));
  endfunction

  haraka_ctrl_state_t state_r, state_nxt_s;
  logic [LEN_W-1:0]   rem_r, rem_nxt_s;
  logic               last_r, last_nxt_s;
  logic               in_ready_r, out_valid_r, out_last_r, busy_r;
  logic [5:0]         out_nbytes_r;
  logic               in_hs_s, out_hs_s, seq_start_s, seq_last_s, done_s;

  // Handshakes; nothing is accepted in a reset cycle.
  assign in_hs_s  = in_valid & in_ready_r & ~reset;
  assign out_hs_s = out_valid_r & out_ready & ~reset;

  haraka_s_round_seq #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RND_W      (RND_W)
  ) u_round_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (seq_start_s),
    .round_en   (perm_round_en),
    .round      (perm_round),
    .last_round (seq_last_s)
  );

  // Next-state, remaining-byte and last-flag computation.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    last_nxt_s  = last_r;
    seq_start_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_hs_s) begin
          rem_nxt_s   = digest_len;
          last_nxt_s  = in_last;
          state_nxt_s = PERM;
          seq_start_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ABSORB: begin
        if (in_hs_s) begin
          last_nxt_s  = in_last;
          state_nxt_s = PERM;
          seq_start_s = 1'b1;
        end else begin
          state_nxt_s = ABSORB;
        end
      end
      PERM: begin
        if (seq_last_s) begin
          if (!last_r) begin
            state_nxt_s = ABSORB;
          end else if (rem_r != '0) begin
            state_nxt_s = SQ_OUT;
          end else begin
            // Zero-length digest: finish straight after the final permutation.
            state_nxt_s = IDLE;
            done_s      = 1'b1;
          end
        end else begin
          state_nxt_s = PERM;
        end
      end
      SQ_OUT: begin
        if (out_hs_s) begin
          rem_nxt_s = rem_r - LEN_W'(out_nbytes_r);
          if (out_last_r) begin
            state_nxt_s = IDLE;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = SQ_PERM;
            seq_start_s = 1'b1;
          end
        end else begin
          state_nxt_s = SQ_OUT;
        end
      end
      SQ_PERM: begin
        if (seq_last_s) begin
          state_nxt_s = SQ_OUT;
        end else begin
          state_nxt_s = SQ_PERM;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state plus registered outputs decoded from the next state, so the
  // output block fields are fixed on entry to SQ_OUT and hold until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      rem_r        <= '0;
      last_r       <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_nbytes_r <= 6'd0;
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      rem_r        <= rem_nxt_s;
      last_r       <= last_nxt_s;
      in_ready_r   <= (state_nxt_s == IDLE) || (state_nxt_s == ABSORB);
      out_valid_r  <= (state_nxt_s == SQ_OUT);
      out_nbytes_r <= (state_nxt_s == SQ_OUT) ? block_bytes(rem_nxt_s) : 6'd0;
      out_last_r   <= (state_nxt_s == SQ_OUT) ? is_final(rem_nxt_s) : 1'b0;
      busy_r       <= (state_nxt_s != IDLE);
    end
  end

  // Datapath strobes follow the handshake in the same cycle.
  assign absorb_en  = in_hs_s;
  assign state_clr  = in_hs_s & (state_r == IDLE);
  assign done       = done_s & ~reset;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_nbytes = out_nbytes_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_haraka_s_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_haraka_s_sponge_ctrl
//   Directed bench. Stimulus tasks push the expected digest blocks into a
//   scoreboard queue; a negedge monitor pops and compares whenever a block is
//   handed over. Cycle-level strobes are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_haraka_s_sponge_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] digest_len;
  logic        state_clr;
  logic        absorb_en;
  logic        perm_round_en;
  logic [2:0]  perm_round;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_nbytes;
  logic        out_last;
  logic        busy;
  logic        done;

  typedef struct {
    logic [5:0] nb;
    logic       lst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  haraka_s_sponge_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .digest_len    (digest_len),
    .state_clr     (state_clr),
    .absorb_en     (absorb_en),
    .perm_round_en (perm_round_en),
    .perm_round    (perm_round),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_nbytes    (out_nbytes),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the active edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare each handed-over digest block.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got block nbytes=%0d expected none", out_nbytes);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_nbytes", 64'(out_nbytes), 64'(mon_e.nb));
        chk("sb_last", 64'(out_last), 64'(mon_e.lst));
      end
    end
  end

  // Count completion pulses.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  // Present one block in a cycle where in_ready is expected, then walk the
  // five rounds. Ends at the first cycle after the permutation.
  task automatic send_block(input logic [63:0] len, input logic lst,
                            input logic first, input logic exp_done);
    in_valid = 1'b1; in_last = lst; digest_len = len; #1;
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_absorb_en", 64'(absorb_en), 64'd1);
    chk("hs_state_clr", 64'(state_clr), 64'(first));
    chk("hs_round_en", 64'(perm_round_en), 64'd0);
    next_cycle();
    digest_len = 64'hDEAD_BEEF_0000_0001;
    for (int r = 0; r < 5; r++) begin
      in_valid = (r == 2); in_last = 1'b0; #1;
      chk("perm_round_en", 64'(perm_round_en), 64'd1);
      chk("perm_round", 64'(perm_round), 64'(r));
      chk("perm_in_ready", 64'(in_ready), 64'd0);
      chk("perm_absorb_en", 64'(absorb_en), 64'd0);
      chk("perm_done", 64'(done), (r == 4) ? 64'(exp_done) : 64'd0);
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  // Take one digest block after 'stall' cycles of back-pressure.
  task automatic squeeze(input logic [5:0] nb, input logic lst, input int stall);
    exp_t e;
    out_ready = 1'b0; #1;
    e.nb = nb; e.lst = lst;
    exp_q.push_back(e);
    chk("sq_out_valid", 64'(out_valid), 64'd1);
    chk("sq_nbytes", 64'(out_nbytes), 64'(nb));
    chk("sq_last", 64'(out_last), 64'(lst));
    chk("sq_in_ready", 64'(in_ready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      next_cycle(); #1;
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_nbytes", 64'(out_nbytes), 64'(nb));
    end
    out_ready = 1'b1; #1;
    chk("sq_done", 64'(done), 64'(lst));
    next_cycle();
    out_ready = 1'b0;
    if (!lst) begin
      for (int r = 0; r < 5; r++) begin
        in_valid = (r == 1); out_ready = (r == 3); #1;
        chk("sqp_round_en", 64'(perm_round_en), 64'd1);
        chk("sqp_round", 64'(perm_round), 64'(r));
        chk("sqp_out_valid", 64'(out_valid), 64'd0);
        chk("sqp_absorb_en", 64'(absorb_en), 64'd0);
        next_cycle();
      end
      in_valid = 1'b0; out_ready = 1'b0;
    end else begin
      #1;
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_in_ready", 64'(in_ready), 64'd1);
      chk("end_out_valid", 64'(out_valid), 64'd0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_round_en", 64'(perm_round_en), 64'd0);
    chk("rst_round", 64'(perm_round), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    digest_len = 64'd0; out_ready = 1'b0;
    repeat (3) next_cycle();
    apply_reset();
    chk("rst_out_nbytes", 64'(out_nbytes), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    next_cycle();

    // Single block, 32-byte digest.
    send_block(64'd32, 1'b1, 1'b1, 1'b0);
    squeeze(6'd32, 1'b1, 0);
    next_cycle();

    // Three blocks, 64-byte digest; later digest_len values are ignored.
    send_block(64'd64, 1'b0, 1'b1, 1'b0);
    #1 chk("abs_busy", 64'(busy), 64'd1);
    chk("abs_out_valid", 64'(out_valid), 64'd0);
    send_block(64'd5, 1'b0, 1'b0, 1'b0);
    send_block(64'd7, 1'b1, 1'b0, 1'b0);
    squeeze(6'd32, 1'b0, 0);
    squeeze(6'd32, 1'b1, 0);
    next_cycle();

    // 45-byte digest with 10 cycles of back-pressure on the first block.
    send_block(64'd45, 1'b1, 1'b1, 1'b0);
    squeeze(6'd32, 1'b0, 10);
    squeeze(6'd13, 1'b1, 0);
    next_cycle();

    // Zero-length digest: done at the final round, no output block.
    send_block(64'd0, 1'b1, 1'b1, 1'b1);
    #1 chk("zero_out_valid", 64'(out_valid), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_in_ready", 64'(in_ready), 64'd1);
    next_cycle();

    // Reset during SQ_PERM round 2.
    send_block(64'd64, 1'b1, 1'b1, 1'b0);
    begin
      exp_t e;
      e.nb = 6'd32; e.lst = 1'b0;
      exp_q.push_back(e);
    end
    out_ready = 1'b1; #1;
    chk("ab_done_hs", 64'(done), 64'd0);
    next_cycle();
    out_ready = 1'b0;
    next_cycle();
    next_cycle(); #1;
    chk("ab_round", 64'(perm_round), 64'd2);
    chk("ab_round_en", 64'(perm_round_en), 64'd1);
    apply_reset();
    next_cycle();

    // New message after the abort runs normally; 31-byte digest.
    send_block(64'd31, 1'b1, 1'b1, 1'b0);
    squeeze(6'd31, 1'b1, 0);
    next_cycle();

    // Maximum digest length: full blocks, never the last one.
    send_block(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_block(64'd3, 1'b1, 1'b0, 1'b0);
    squeeze(6'd32, 1'b0, 0);
    squeeze(6'd32, 1'b0, 0);
    #1 chk("max_nbytes", 64'(out_nbytes), 64'd32);
    chk("max_last", 64'(out_last), 64'd0);
    apply_reset();
    next_cycle();

    chk("done_count", 64'(done_seen), 64'd5);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
